// File: rtl/dcache_pkg.sv
// Shared types and width defaults for the data-cache responder
// and its data RAM.
package dcache_pkg;

    localparam int ADDR_WIDTH_DEF     = 32;
    localparam int DATA_WIDTH_DEF     = 32;
    localparam int BYTE_SEL_WIDTH_DEF = DATA_WIDTH_DEF / 8;
    localparam int CNT_WIDTH          = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_e;

    typedef enum logic {
        REQ_STORE,
        REQ_LOAD
    } req_type_e;

endpackage

// File: rtl/dcache_data_ram.sv
// Single-port word RAM with per-byte write enables and a registered read.
// Each byte lane is its own array so the tools can map it onto byte-enabled block RAM.
module dcache_data_ram
    import dcache_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int BYTE_SEL_WIDTH = BYTE_SEL_WIDTH_DEF,
    localparam int IDX_W         = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic [IDX_W-1:0]          addr,
    input  logic                      we,
    input  logic [BYTE_SEL_WIDTH-1:0] be,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < BYTE_SEL_WIDTH; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q_reg;

            // Read-before-write: a read on the write edge returns the old byte.
            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    lane_mem[addr] <= wdata[gi*8 +: 8];
                end
                lane_q_reg <= lane_mem[addr];
            end

            assign rdata[gi*8 +: 8] = lane_q_reg;
        end
    endgenerate

endmodule

// File: rtl/dcache_stb_responder.sv
// Data-cache responder: commits store-buffer drains into a byte-enabled RAM and
// serves LSU loads only while the store buffer is empty, acking each after a fixed latency.
module dcache_stb_responder
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int BYTE_SEL_WIDTH = BYTE_SEL_WIDTH_DEF,
    parameter int MEM_DEPTH      = 256,
    parameter int ACK_LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
    input  logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
    input  logic                      stb2dcache_w_en,
    input  logic                      stb2dcache_req,
    input  logic                      stb2dcache_dmem_sel,
    input  logic                      stb2dcache_empty,
    output logic                      dcache2stb_ack,
    input  logic [ADDR_WIDTH-1:0]     lsudbus2dcache_addr,
    input  logic                      lsudbus2dcache_req,
    output logic                      dcache2lsudbus_ack,
    output logic [DATA_WIDTH-1:0]     dcache2lsudbus_rdata
);

    localparam int                   IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(ACK_LATENCY - 1);

    resp_state_e               state_reg;
    req_type_e                 type_reg;
    logic [CNT_WIDTH-1:0]      cnt_reg;
    logic                      stb_ack_reg;
    logic                      lsu_ack_reg;
    logic [DATA_WIDTH-1:0]     rdata_hold_reg;

    logic [IDX_W-1:0]          idx_reg;
    logic [DATA_WIDTH-1:0]     wdata_reg;
    logic [BYTE_SEL_WIDTH-1:0] sel_reg;
    logic                      w_en_reg;
    logic                      dmem_sel_reg;

    logic [IDX_W-1:0]          stb_idx;
    logic [IDX_W-1:0]          lsu_idx;
    logic [IDX_W-1:0]          ram_addr;
    logic [DATA_WIDTH-1:0]     ram_q;
    logic [DATA_WIDTH-1:0]     load_data;
    logic                      ram_we;
    logic                      accept_store;
    logic                      accept_load;
    logic                      unused_addr_bits;

    // Word index only; byte offset and bits above the RAM depth alias.
    assign stb_idx = stb2dcache_addr[IDX_W+1:2];
    assign lsu_idx = lsudbus2dcache_addr[IDX_W+1:2];
    assign unused_addr_bits = ^{stb2dcache_addr[ADDR_WIDTH-1:IDX_W+2], stb2dcache_addr[1:0],
                                lsudbus2dcache_addr[ADDR_WIDTH-1:IDX_W+2], lsudbus2dcache_addr[1:0]};

    assign accept_store = (state_reg == IDLE) && stb2dcache_req;
    assign accept_load  = (state_reg == IDLE) && !stb2dcache_req
                          && lsudbus2dcache_req && stb2dcache_empty;

    // In IDLE the RAM already reads the incoming load address so a one-cycle latency has data ready.
    assign ram_addr = (state_reg == IDLE) ? lsu_idx : idx_reg;
    assign ram_we   = (state_reg == RESP) && (type_reg == REQ_STORE)
                      && w_en_reg && dmem_sel_reg && !rst;

    dcache_data_ram #(
        .DEPTH          (MEM_DEPTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .BYTE_SEL_WIDTH (BYTE_SEL_WIDTH)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (sel_reg),
        .wdata (wdata_reg),
        .rdata (ram_q)
    );

    assign load_data = dmem_sel_reg ? ram_q : '0;

    always_ff @(posedge clk) begin
        if (accept_store) begin
            idx_reg      <= stb_idx;
            wdata_reg    <= stb2dcache_wdata;
            sel_reg      <= stb2dcache_sel_byte;
            w_en_reg     <= stb2dcache_w_en;
            dmem_sel_reg <= stb2dcache_dmem_sel;
        end else if (accept_load) begin
            idx_reg      <= lsu_idx;
            w_en_reg     <= 1'b0;
            dmem_sel_reg <= stb2dcache_dmem_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            type_reg       <= REQ_STORE;
            cnt_reg        <= '0;
            stb_ack_reg    <= 1'b0;
            lsu_ack_reg    <= 1'b0;
            rdata_hold_reg <= '0;
        end else begin
            stb_ack_reg <= 1'b0;
            lsu_ack_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (accept_store || accept_load) begin
                        type_reg <= accept_store ? REQ_STORE : REQ_LOAD;
                        cnt_reg  <= CNT_LOAD;
                        if (ACK_LATENCY == 1) begin
                            state_reg   <= RESP;
                            stb_ack_reg <= accept_store;
                            lsu_ack_reg <= accept_load;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - CNT_WIDTH'(1);
                    if (cnt_reg == CNT_WIDTH'(1)) begin
                        state_reg   <= RESP;
                        stb_ack_reg <= (type_reg == REQ_STORE);
                        lsu_ack_reg <= (type_reg == REQ_LOAD);
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    if (type_reg == REQ_LOAD) begin
                        rdata_hold_reg <= load_data;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign dcache2stb_ack       = stb_ack_reg;
    assign dcache2lsudbus_ack   = lsu_ack_reg;
    // Fresh RAM data during the ack cycle, then the captured word until the next load ack.
    assign dcache2lsudbus_rdata = lsu_ack_reg ? load_data : rdata_hold_reg;

endmodule

// File: tb/tb_dcache_stb_responder.sv
// Bench for dcache_stb_responder: instance A uses ACK_LATENCY=2, instance B ACK_LATENCY=1,
// both checked against a word/byte-level memory model.
module tb_dcache_stb_responder;

    localparam int DEPTH  = 256;
    localparam int PERIOD = 10;

    logic clk = 1'b0;
    always #(PERIOD/2) clk = ~clk;
    logic rst;

    logic [31:0] a_st_addr, a_wdata, a_ld_addr, a_rdata;
    logic [3:0]  a_sel;
    logic        a_w_en, a_st_req, a_dmem, a_empty, a_ld_req, a_st_ack, a_ld_ack;
    logic [31:0] b_st_addr, b_wdata, b_ld_addr, b_rdata;
    logic [3:0]  b_sel;
    logic        b_w_en, b_st_req, b_dmem, b_empty, b_ld_req, b_st_ack, b_ld_ack;

    dcache_stb_responder #(.MEM_DEPTH(DEPTH), .ACK_LATENCY(2)) dut_a (
        .clk(clk), .rst(rst),
        .stb2dcache_addr(a_st_addr), .stb2dcache_wdata(a_wdata), .stb2dcache_sel_byte(a_sel),
        .stb2dcache_w_en(a_w_en), .stb2dcache_req(a_st_req), .stb2dcache_dmem_sel(a_dmem),
        .stb2dcache_empty(a_empty), .dcache2stb_ack(a_st_ack),
        .lsudbus2dcache_addr(a_ld_addr), .lsudbus2dcache_req(a_ld_req),
        .dcache2lsudbus_ack(a_ld_ack), .dcache2lsudbus_rdata(a_rdata)
    );

    dcache_stb_responder #(.MEM_DEPTH(DEPTH), .ACK_LATENCY(1)) dut_b (
        .clk(clk), .rst(rst),
        .stb2dcache_addr(b_st_addr), .stb2dcache_wdata(b_wdata), .stb2dcache_sel_byte(b_sel),
        .stb2dcache_w_en(b_w_en), .stb2dcache_req(b_st_req), .stb2dcache_dmem_sel(b_dmem),
        .stb2dcache_empty(b_empty), .dcache2stb_ack(b_st_ack),
        .lsudbus2dcache_addr(b_ld_addr), .lsudbus2dcache_req(b_ld_req),
        .dcache2lsudbus_ack(b_ld_ack), .dcache2lsudbus_rdata(b_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference memory: one word per index, keyed by (addr/4) mod DEPTH.
    logic [31:0] model_a [int];
    logic [31:0] model_b [int];

    function automatic int idx_of(input logic [31:0] addr);
        return int'((addr / 32'd4) % 32'(DEPTH));
    endfunction

    task automatic model_store(input int which, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] sel, input logic w_en, input logic dmem);
        int i = idx_of(addr);
        logic [31:0] w;
        if (!(w_en && dmem)) return;
        if (which == 0) w = model_a.exists(i) ? model_a[i] : 32'hx;
        else            w = model_b.exists(i) ? model_b[i] : 32'hx;
        for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = data[8*b +: 8];
        if (which == 0) model_a[i] = w; else model_b[i] = w;
    endtask

    function automatic logic [31:0] model_load(input int which, input logic [31:0] addr, input logic dmem);
        int i = idx_of(addr);
        if (!dmem) return 32'h0;
        return (which == 0) ? model_a[i] : model_b[i];
    endfunction

    function automatic logic get_ack(input int which, input bit is_load);
        if (which == 0) return is_load ? a_ld_ack : a_st_ack;
        return is_load ? b_ld_ack : b_st_ack;
    endfunction

    function automatic logic [31:0] get_rdata(input int which);
        return (which == 0) ? a_rdata : b_rdata;
    endfunction

    task automatic drive(input int which, input bit is_load, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel, input logic w_en, input logic dmem, input logic req);
        if (which == 0) begin
            a_st_addr = addr; a_wdata = data; a_sel = sel; a_w_en = w_en; a_dmem = dmem; a_empty = 1'b1;
            a_ld_addr = addr; a_st_req = req && !is_load; a_ld_req = req && is_load;
        end else begin
            b_st_addr = addr; b_wdata = data; b_sel = sel; b_w_en = w_en; b_dmem = dmem; b_empty = 1'b1;
            b_ld_addr = addr; b_st_req = req && !is_load; b_ld_req = req && is_load;
        end
    endtask

    // Runs one request from a negedge; returns latency in edges (0 = timed out).
    task automatic txn(input int which, input bit is_load, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] sel, input logic w_en, input logic dmem,
                       output int lat, output logic width_ok, output logic [31:0] rd,
                       output logic [31:0] rd_hold, output time t_ack);
        drive(which, is_load, addr, data, sel, w_en, dmem, 1'b1);
        lat = 0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk); @(negedge clk);
            if (get_ack(which, is_load)) begin lat = n; break; end
        end
        rd = get_rdata(which);
        t_ack = $time;
        drive(which, is_load, addr, data, sel, w_en, dmem, 1'b0);
        @(posedge clk); @(negedge clk);
        width_ok = !get_ack(which, is_load);
        rd_hold = get_rdata(which);
        $display("txn dut%0d %s addr=%08h wdata=%08h sel=%b w_en=%b dmem=%b lat=%0d rdata=%08h",
                 which, is_load ? "load " : "store", addr, data, sel, w_en, dmem, lat, rd);
    endtask

    int lat; logic wok; logic [31:0] rd, rh, d, exp_v; time t1, t2, t3;

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (a_st_ack !== 1'b0) begin n_bad++; $display("FAIL reset_st_ack: got %b want 0", a_st_ack); end
        n_cmp++; if (a_ld_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ld_ack: got %b want 0", a_ld_ack); end
        n_cmp++; if (a_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", a_rdata); end
        n_cmp++; if (b_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata_b: got %h want 0", b_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        txn(0, 0, 32'h1000, 32'hAAAA_BBBB, 4'hF, 1, 1, lat, wok, rd, rh, t1);
        model_store(0, 32'h1000, 32'hAAAA_BBBB, 4'hF, 1, 1);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL store_latency: got %0d want 2", lat); end
        n_cmp++; if (wok !== 1'b1) begin n_bad++; $display("FAIL store_ack_width: ack still high next cycle"); end
        txn(0, 1, 32'h1000, 32'h0, 4'h0, 0, 1, lat, wok, rd, rh, t1);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL load_latency: got %0d want 2", lat); end
        n_cmp++; if (rd !== 32'hAAAA_BBBB) begin n_bad++; $display("FAIL load_data: got %h want %h", rd, 32'hAAAA_BBBB); end
        n_cmp++; if (rh !== 32'hAAAA_BBBB) begin n_bad++; $display("FAIL load_data_hold: got %h want %h", rh, 32'hAAAA_BBBB); end
        n_cmp++; if (wok !== 1'b1) begin n_bad++; $display("FAIL load_ack_width: ack still high next cycle"); end
    endtask

    task automatic test_byte_merge();
        txn(0, 0, 32'h1004, 32'hCCCC_DDDD, 4'hF, 1, 1, lat, wok, rd, rh, t1);
        model_store(0, 32'h1004, 32'hCCCC_DDDD, 4'hF, 1, 1);
        txn(0, 0, 32'h1004, 32'h1122_3344, 4'b0101, 1, 1, lat, wok, rd, rh, t1);
        model_store(0, 32'h1004, 32'h1122_3344, 4'b0101, 1, 1);
        txn(0, 1, 32'h1004, 32'h0, 4'h0, 0, 1, lat, wok, rd, rh, t1);
        exp_v = model_load(0, 32'h1004, 1);
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL byte_merge: got %h want %h", rd, exp_v); end
    endtask

    task automatic test_arbitration();
        logic ld_early = 1'b0;
        int st_n = 0, ld_n = 0;
        d = $urandom();
        a_st_addr = 32'h100C; a_wdata = d; a_sel = 4'hF; a_w_en = 1; a_dmem = 1; a_empty = 0;
        a_ld_addr = 32'h100C; a_st_req = 1; a_ld_req = 1;
        model_store(0, 32'h100C, d, 4'hF, 1, 1);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); @(negedge clk);
            if (a_ld_ack) ld_early = 1;
            if (a_st_ack) begin st_n = n; break; end
        end
        a_st_req = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); @(negedge clk);
            if (a_ld_ack) ld_early = 1;
        end
        n_cmp++; if (st_n !== 2) begin n_bad++; $display("FAIL arb_store_first: got %0d want 2", st_n); end
        n_cmp++; if (ld_early !== 1'b0) begin n_bad++; $display("FAIL arb_load_held: got ack=%b want 0", ld_early); end
        a_empty = 1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); @(negedge clk);
            if (a_ld_ack) begin ld_n = n; rd = a_rdata; break; end
        end
        a_ld_req = 0;
        @(posedge clk); @(negedge clk);
        $display("txn dut0 arb   store=%08h load_lat=%0d rdata=%08h", d, ld_n, rd);
        n_cmp++; if (ld_n !== 2) begin n_bad++; $display("FAIL arb_load_latency: got %0d want 2", ld_n); end
        n_cmp++; if (rd !== d) begin n_bad++; $display("FAIL arb_load_data: got %h want %h", rd, d); end
    endtask

    task automatic test_no_write();
        txn(0, 0, 32'h1008, 32'h0, 4'hF, 1, 1, lat, wok, rd, rh, t1);
        model_store(0, 32'h1008, 32'h0, 4'hF, 1, 1);
        d = $urandom();
        txn(0, 0, 32'h1008, d, 4'hF, 1, 0, lat, wok, rd, rh, t1);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL nodmem_ack: got lat %0d want 2", lat); end
        txn(0, 0, 32'h1008, ~d, 4'hF, 0, 1, lat, wok, rd, rh, t1);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL nowen_ack: got lat %0d want 2", lat); end
        txn(0, 1, 32'h1008, 32'h0, 4'h0, 0, 1, lat, wok, rd, rh, t1);
        exp_v = model_load(0, 32'h1008, 1);
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL nowrite_data: got %h want %h", rd, exp_v); end
        txn(0, 1, 32'h1000, 32'h0, 4'h0, 0, 0, lat, wok, rd, rh, t1);
        exp_v = model_load(0, 32'h1000, 0);
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL load_dmem_low: got %h want %h", rd, exp_v); end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        d = $urandom();
        drive(0, 0, 32'h1000, d, 4'hF, 1, 1, 1);
        @(posedge clk); @(negedge clk);
        if (a_st_ack) seen = 1;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 32'h1000, d, 4'hF, 1, 1, 0);
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); @(negedge clk);
            if (a_st_ack) seen = 1;
        end
        $display("txn dut0 store addr=00001000 wdata=%08h aborted by reset", d);
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_ack: got ack=%b want 0", seen); end
        txn(0, 1, 32'h1000, 32'h0, 4'h0, 0, 1, lat, wok, rd, rh, t1);
        exp_v = model_load(0, 32'h1000, 1);
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL rst_mid_ram_kept: got %h want %h", rd, exp_v); end
        txn(0, 0, 32'h1000, d, 4'hF, 1, 1, lat, wok, rd, rh, t1);
        model_store(0, 32'h1000, d, 4'hF, 1, 1);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL retry_latency: got %0d want 2", lat); end
        txn(0, 1, 32'h1000, 32'h0, 4'h0, 0, 1, lat, wok, rd, rh, t1);
        n_cmp++; if (rd !== d) begin n_bad++; $display("FAIL retry_data: got %h want %h", rd, d); end
    endtask

    task automatic test_alias();
        d = $urandom();
        txn(0, 0, 32'h1000 + 4*DEPTH, d, 4'hF, 1, 1, lat, wok, rd, rh, t1);
        model_store(0, 32'h1000 + 4*DEPTH, d, 4'hF, 1, 1);
        txn(0, 1, 32'h1000, 32'h0, 4'h0, 0, 1, lat, wok, rd, rh, t1);
        exp_v = model_load(0, 32'h1000, 1);
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL alias_data: got %h want %h", rd, exp_v); end
    endtask

    task automatic test_back_to_back();
        txn(0, 0, 32'h1010, $urandom(), 4'hF, 1, 1, lat, wok, rd, rh, t1);
        txn(0, 0, 32'h1014, $urandom(), 4'hF, 1, 1, lat, wok, rd, rh, t2);
        txn(0, 1, 32'h1000, 32'h0, 4'h0, 0, 1, lat, wok, rd, rh, t3);
        n_cmp++; if (t2 - t1 !== 3*PERIOD) begin n_bad++; $display("FAIL b2b_store_spacing: got %0t want %0d", t2 - t1, 3*PERIOD); end
        n_cmp++; if (t3 - t2 !== 3*PERIOD) begin n_bad++; $display("FAIL b2b_load_spacing: got %0t want %0d", t3 - t2, 3*PERIOD); end
    endtask

    task automatic test_random();
        logic [31:0] addr; logic [3:0] sel; logic w_en, dmem; int k, op;
        for (int i = 0; i < 16; i++) begin
            d = $urandom();
            txn(0, 0, 32'h2000 + 4*i, d, 4'hF, 1, 1, lat, wok, rd, rh, t1);
            model_store(0, 32'h2000 + 4*i, d, 4'hF, 1, 1);
        end
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 15);
            addr = ($urandom() & 32'hFFFF_FC00) | 32'(k * 4) | 32'($urandom_range(0, 3));
            op = $urandom_range(0, 2);
            dmem = ($urandom_range(0, 3) != 0);
            if (op < 2) begin
                d = $urandom(); sel = 4'($urandom()); w_en = ($urandom_range(0, 3) != 0);
                txn(0, 0, addr, d, sel, w_en, dmem, lat, wok, rd, rh, t1);
                model_store(0, addr, d, sel, w_en, dmem);
                n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rand_store_lat: got %0d want 2", lat); end
            end else begin
                txn(0, 1, addr, 32'h0, 4'h0, 0, dmem, lat, wok, rd, rh, t1);
                exp_v = model_load(0, addr, dmem);
                n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL rand_load_data: addr %h got %h want %h", addr, rd, exp_v); end
            end
        end
    endtask

    task automatic test_latency1();
        d = $urandom();
        txn(1, 0, 32'h1000, d, 4'hF, 1, 1, lat, wok, rd, rh, t1);
        model_store(1, 32'h1000, d, 4'hF, 1, 1);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL lat1_store: got %0d want 1", lat); end
        n_cmp++; if (wok !== 1'b1) begin n_bad++; $display("FAIL lat1_ack_width: ack still high next cycle"); end
        txn(1, 0, 32'h1000 + 4*DEPTH, 32'h5A6B_7C8D, 4'b1010, 1, 1, lat, wok, rd, rh, t1);
        model_store(1, 32'h1000 + 4*DEPTH, 32'h5A6B_7C8D, 4'b1010, 1, 1);
        txn(1, 1, 32'h1000, 32'h0, 4'h0, 0, 1, lat, wok, rd, rh, t1);
        exp_v = model_load(1, 32'h1000, 1);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL lat1_load: got %0d want 1", lat); end
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL lat1_alias_data: got %h want %h", rd, exp_v); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_merge();
        test_arbitration();
        test_no_write();
        test_reset_mid();
        test_alias();
        test_back_to_back();
        test_random();
        test_latency1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
